// File: rtl/draw_pkg.sv
// Shared types and constants for the pipelined pixel compositor: transparency key,
// rope colour, object table entry and the RGB332 -> RGB444 expansion.
package draw_pkg;

  localparam logic [7:0] TRANSP_KEY = 8'hFF;

  localparam logic [3:0] ROPE_R = 4'h9;
  localparam logic [3:0] ROPE_G = 4'h9;
  localparam logic [3:0] ROPE_B = 4'h6;

  // w and h hold size minus 1, so an entry covers x..x+w inclusive
  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [6:0]  w;
    logic [6:0]  h;
    logic        vis;
  } obj_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic rgb444_t expand332(input logic [7:0] c);
    rgb444_t o;
    o.r = {c[7:5], c[7]};
    o.g = {c[4:2], c[4]};
    o.b = {c[1:0], c[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/draw_rope_test.sv
// Combinational rope band test: pixel lies within ROPE_W pixels on the anchor side of
// the line from the anchor to (hook_x+10, hook_y), between the anchor row and hook_y.
module draw_rope_test #(
  parameter int ANCHOR_X = 635,
  parameter int ANCHOR_Y = 167,
  parameter int ROPE_W   = 7
) (
  input  logic [10:0] i_px,
  input  logic [9:0]  i_py,
  input  logic [10:0] i_hook_x,
  input  logic [9:0]  i_hook_y,
  output logic        o_hit
);

  logic signed [12:0] w_dx;
  logic signed [12:0] w_rx;
  logic signed [11:0] w_dy;
  logic signed [11:0] w_ry;
  logic signed [23:0] w_cross;
  logic signed [23:0] w_band;

  assign w_dx = 13'(i_hook_x) + 13'sd10 - 13'(ANCHOR_X);
  assign w_dy = 12'(i_hook_y) - 12'(ANCHOR_Y);
  assign w_rx = 13'(i_px) - 13'(ANCHOR_X);
  assign w_ry = 12'(i_py) - 12'(ANCHOR_Y);

  // Cross product sign tells which side of the rope line the pixel is on; the band
  // spans (line_x - ROPE_W, line_x] at this row, scaled by dy to avoid a divide.
  assign w_cross = 24'(w_rx) * 24'(w_dy) - 24'(w_dx) * 24'(w_ry);
  assign w_band  = 24'(ROPE_W) * 24'(w_dy);

  assign o_hit = (w_dy > 12'sd0) && (w_ry >= 12'sd0) && (i_py <= i_hook_y) &&
                 (w_cross <= 24'sd0) && (w_cross > -w_band);

endmodule

// File: rtl/draw_compositor.sv
// Three-stage pixel compositor: hit-test/ROM addressing, ROM return, layer merge.
// Optional collision tracking is built when COMPOSE_COLLIDE_EN is defined.
module draw_compositor
  import draw_pkg::*;
#(
  parameter int N_OBJ    = 10,
  parameter int IDX_W    = 4,
  parameter int SCR_W    = 1280,
  parameter int SCR_H    = 800,
  parameter int BORDER   = 10,
  parameter int HOOK_SZ  = 33,
  parameter int ANCHOR_X = 635,
  parameter int ANCHOR_Y = 167,
  parameter int ROPE_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [10:0]      draw_x,
  input  logic [9:0]       draw_y,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [10:0]      wr_x,
  input  logic [9:0]       wr_y,
  input  logic [6:0]       wr_w,
  input  logic [6:0]       wr_h,
  input  logic             wr_vis,
  input  logic [10:0]      hook_x,
  input  logic [9:0]       hook_y,
  input  logic             done_game,
  output logic             spr_req,
  output logic [IDX_W-1:0] spr_idx,
  output logic [6:0]       spr_off_x,
  output logic [6:0]       spr_off_y,
  output logic [5:0]       hook_off_x,
  output logic [5:0]       hook_off_y,
  output logic [10:0]      pix_x_q,
  output logic [9:0]       pix_y_q,
  input  logic [7:0]       spr_data,
  input  logic [7:0]       hook_data,
  input  logic [7:0]       bg_data,
  input  logic [7:0]       end_data,
  output logic [3:0]       draw_r,
  output logic [3:0]       draw_g,
  output logic [3:0]       draw_b,
  output logic             draw_valid
`ifdef COMPOSE_COLLIDE_EN
  ,
  input  logic             collide_clr,
  output logic [N_OBJ-1:0] collide_vec
`endif
);

  // Valid-only pipeline: a pixel accepted with pix_valid moves one stage per clock,
  // no backpressure exists, and draw_valid marks the matching RGB three clocks later.
  obj_t             r_tab [N_OBJ];
  logic [N_OBJ-1:0] w_obj_hit;
  logic             w_hit, w_hook_hit, w_rope_hit, w_border;
  logic [IDX_W-1:0] w_idx;
  logic [6:0]       w_off_x, w_off_y;
  logic             r_v1, r_hook1, r_rope1, r_border1;
  logic             r_v2, r_hit2, r_hook2, r_rope2, r_border2;
  logic [7:0]       r_spr_d2, r_hook_d2, r_bg_d2, r_end_d2;
  rgb444_t          w_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OBJ; i++) r_tab[i] <= '0;
    end else begin
      for (int i = 0; i < N_OBJ; i++)
        if (wr_en && wr_idx == IDX_W'(i)) r_tab[i] <= '{wr_x, wr_y, wr_w, wr_h, wr_vis};
    end
  end

  // Descending scan so the lowest hit index is the last writer and wins
  always_comb begin
    w_hit   = 1'b0;
    w_idx   = '0;
    w_off_x = '0;
    w_off_y = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      w_obj_hit[i] = r_tab[i].vis &&
                     (draw_x >= r_tab[i].x) && (12'(draw_x) <= 12'(r_tab[i].x) + 12'(r_tab[i].w)) &&
                     (draw_y >= r_tab[i].y) && (11'(draw_y) <= 11'(r_tab[i].y) + 11'(r_tab[i].h));
      if (w_obj_hit[i]) begin
        w_hit   = 1'b1;
        w_idx   = IDX_W'(i);
        w_off_x = 7'(draw_x - r_tab[i].x);
        w_off_y = 7'(draw_y - r_tab[i].y);
      end
    end
  end

  assign w_hook_hit = (draw_x >= hook_x) && (12'(draw_x) <= 12'(hook_x) + 12'(HOOK_SZ - 1)) &&
                      (draw_y >= hook_y) && (11'(draw_y) <= 11'(hook_y) + 11'(HOOK_SZ - 1));

  assign w_border = (draw_x < 11'(BORDER)) || (draw_x >= 11'(SCR_W - BORDER)) ||
                    (draw_y < 10'(BORDER)) || (draw_y >= 10'(SCR_H - BORDER));

  draw_rope_test #(
    .ANCHOR_X(ANCHOR_X),
    .ANCHOR_Y(ANCHOR_Y),
    .ROPE_W  (ROPE_W)
  ) u_rope (
    .i_px    (draw_x),
    .i_py    (draw_y),
    .i_hook_x(hook_x),
    .i_hook_y(hook_y),
    .o_hit   (w_rope_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0; spr_req <= 1'b0; spr_idx <= '0; spr_off_x <= '0; spr_off_y <= '0;
      hook_off_x <= '0; hook_off_y <= '0; pix_x_q <= '0; pix_y_q <= '0;
      r_hook1 <= 1'b0; r_rope1 <= 1'b0; r_border1 <= 1'b0;
    end else begin
      r_v1       <= pix_valid;
      spr_req    <= pix_valid && w_hit;
      spr_idx    <= w_idx;
      spr_off_x  <= w_off_x;
      spr_off_y  <= w_off_y;
      hook_off_x <= 6'(draw_x - hook_x);
      hook_off_y <= 6'(draw_y - hook_y);
      pix_x_q    <= draw_x;
      pix_y_q    <= draw_y;
      r_hook1    <= pix_valid && w_hook_hit;
      r_rope1    <= pix_valid && w_rope_hit;
      r_border1  <= pix_valid && w_border;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0; r_hit2 <= 1'b0; r_hook2 <= 1'b0; r_rope2 <= 1'b0; r_border2 <= 1'b0;
      r_spr_d2 <= '0; r_hook_d2 <= '0; r_bg_d2 <= '0; r_end_d2 <= '0;
    end else begin
      r_v2      <= r_v1;
      r_hit2    <= spr_req;
      r_hook2   <= r_hook1;
      r_rope2   <= r_rope1;
      r_border2 <= r_border1;
      r_spr_d2  <= spr_data;
      r_hook_d2 <= hook_data;
      r_bg_d2   <= bg_data;
      r_end_d2  <= end_data;
    end
  end

  always_comb begin
    w_rgb = '0;
    if (r_v2) begin
      if (done_game)                               w_rgb = expand332(r_end_d2);
      else if (r_border2)                          w_rgb = '{4'hF, 4'hF, 4'hF};
      else if (r_hit2 && r_spr_d2 != TRANSP_KEY)   w_rgb = expand332(r_spr_d2);
      else if (r_hook2 && r_hook_d2 != TRANSP_KEY) w_rgb = expand332(r_hook_d2);
      else if (r_rope2)                            w_rgb = '{ROPE_R, ROPE_G, ROPE_B};
      else                                         w_rgb = expand332(r_bg_d2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_valid <= 1'b0; draw_r <= '0; draw_g <= '0; draw_b <= '0;
    end else begin
      draw_valid <= r_v2;
      draw_r     <= w_rgb.r;
      draw_g     <= w_rgb.g;
      draw_b     <= w_rgb.b;
    end
  end

`ifdef COMPOSE_COLLIDE_EN
  logic [IDX_W-1:0] r_idx2;
  logic             w_collide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idx2 <= '0;
    else        r_idx2 <= spr_idx;
  end

  assign w_collide = r_v2 && r_hit2 && (r_spr_d2 != TRANSP_KEY) &&
                     r_hook2 && (r_hook_d2 != TRANSP_KEY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collide_vec <= '0;
    end else if (collide_clr) begin
      collide_vec <= '0;
    end else begin
      for (int i = 0; i < N_OBJ; i++)
        if (w_collide && r_idx2 == IDX_W'(i)) collide_vec[i] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_draw_compositor.sv
// Directed bench for draw_compositor: vector table plus hand sequences for write
// timing, back-to-back pixels, mid-frame reset and (optionally) collision tracking.
module tb_draw_compositor;

  logic        clk, rst_n, pix_valid, wr_en, wr_vis, done_game;
  logic [10:0] draw_x, wr_x, hook_x, pix_x_q;
  logic [9:0]  draw_y, wr_y, hook_y, pix_y_q;
  logic [3:0]  wr_idx, spr_idx;
  logic [6:0]  wr_w, wr_h, spr_off_x, spr_off_y;
  logic [5:0]  hook_off_x, hook_off_y;
  logic [7:0]  spr_data, hook_data, bg_data, end_data;
  logic        spr_req, draw_valid;
  logic [3:0]  draw_r, draw_g, draw_b;
`ifdef COMPOSE_COLLIDE_EN
  logic        collide_clr;
  logic [9:0]  collide_vec;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  draw_compositor dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .draw_x(draw_x), .draw_y(draw_y),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h),
    .wr_vis(wr_vis), .hook_x(hook_x), .hook_y(hook_y), .done_game(done_game),
    .spr_req(spr_req), .spr_idx(spr_idx), .spr_off_x(spr_off_x), .spr_off_y(spr_off_y),
    .hook_off_x(hook_off_x), .hook_off_y(hook_off_y), .pix_x_q(pix_x_q), .pix_y_q(pix_y_q),
    .spr_data(spr_data), .hook_data(hook_data), .bg_data(bg_data), .end_data(end_data),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b), .draw_valid(draw_valid)
`ifdef COMPOSE_COLLIDE_EN
    , .collide_clr(collide_clr), .collide_vec(collide_vec)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] x;   logic [9:0] y;
    logic [10:0] hx;  logic [9:0] hy;
    logic [7:0]  spr; logic [7:0] hk; logic [7:0] bg; logic [7:0] en;
    logic        done;
    logic        req; logic [3:0] idx; logic [6:0] ox; logic [6:0] oy;
    logic        chk_hk; logic [5:0] hox; logic [5:0] hoy;
    logic [11:0] rgb;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_obj(input logic [3:0] idx, input logic [10:0] x, input logic [9:0] y,
                        input logic [6:0] w, input logic [6:0] h, input logic vis);
    wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_w = w; wr_h = h; wr_vis = vis;
    step();
    wr_en = 1'b0;
  endtask

  function automatic void add(input logic [10:0] x, input logic [9:0] y,
                              input logic [10:0] hx, input logic [9:0] hy,
                              input logic [7:0] spr, input logic [7:0] hk,
                              input logic [7:0] bg, input logic [7:0] en, input logic done,
                              input logic req, input logic [3:0] idx,
                              input logic [6:0] ox, input logic [6:0] oy,
                              input logic chk_hk, input logic [5:0] hox, input logic [5:0] hoy,
                              input logic [11:0] rgb);
    vec_t v;
    v.x = x; v.y = y; v.hx = hx; v.hy = hy; v.spr = spr; v.hk = hk; v.bg = bg; v.en = en;
    v.done = done; v.req = req; v.idx = idx; v.ox = ox; v.oy = oy;
    v.chk_hk = chk_hk; v.hox = hox; v.hoy = hoy; v.rgb = rgb;
    vq.push_back(v);
  endfunction

  // driver: one isolated pixel through all three stages, ROM data supplied on time
  task automatic run_vec(input vec_t v, input int n);
    pix_valid = 1'b1; draw_x = v.x; draw_y = v.y; hook_x = v.hx; hook_y = v.hy;
    step();
    check($sformatf("v%0d_req", n), 32'(spr_req), 32'(v.req));
    if (v.req) begin
      check($sformatf("v%0d_idx", n), 32'(spr_idx), 32'(v.idx));
      check($sformatf("v%0d_offx", n), 32'(spr_off_x), 32'(v.ox));
      check($sformatf("v%0d_offy", n), 32'(spr_off_y), 32'(v.oy));
    end
    if (v.chk_hk) begin
      check($sformatf("v%0d_hoffx", n), 32'(hook_off_x), 32'(v.hox));
      check($sformatf("v%0d_hoffy", n), 32'(hook_off_y), 32'(v.hoy));
    end
    pix_valid = 1'b0;
    spr_data = v.spr; hook_data = v.hk; bg_data = v.bg; end_data = v.en;
    step();
    check($sformatf("v%0d_early_valid", n), 32'(draw_valid), 32'd0);
    done_game = v.done;
    exp_q.push_back(v.rgb);
    step();
    check($sformatf("v%0d_valid", n), 32'(draw_valid), 32'd1);
    check($sformatf("v%0d_rgb", n), 32'({draw_r, draw_g, draw_b}), 32'(exp_q.pop_front()));
    done_game = 1'b0;
    step();
    check($sformatf("v%0d_bubble_rgb", n), 32'({draw_valid, draw_r, draw_g, draw_b}), 32'd0);
  endtask

  initial begin
    logic [11:0] pipe_exp [3];
    logic [7:0]  pipe_bg  [3];
    vec_t        v;

    rst_n = 1'b0; pix_valid = 1'b0; draw_x = '0; draw_y = '0;
    wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_w = '0; wr_h = '0; wr_vis = 1'b0;
    hook_x = 11'd1000; hook_y = 10'd100; done_game = 1'b0;
    spr_data = '0; hook_data = '0; bg_data = '0; end_data = '0;
`ifdef COMPOSE_COLLIDE_EN
    collide_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("reset_out", 32'({draw_valid, draw_r, draw_g, draw_b, spr_req}), 32'd0);
    check("reset_addr", 32'({pix_x_q, pix_y_q, spr_idx}), 32'd0);
`ifdef COMPOSE_COLLIDE_EN
    check("reset_collide", 32'(collide_vec), 32'd0);
`endif

    // first vector runs on an empty table
    add(100, 100, 1000, 100, 8'h00, 8'h00, 8'h1C, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0F0);
    run_vec(vq.pop_front(), 0);

    wr_obj(0, 200, 300, 59, 59, 1);
    wr_obj(1, 0, 390, 20, 20, 1);
    wr_obj(2, 400, 500, 19, 19, 1);
    wr_obj(5, 405, 505, 19, 19, 1);
    wr_obj(7, 1000, 100, 9, 9, 1);

    //   x     y    hx    hy   spr    hk     bg     en   dn rq id ox  oy  ck hox hoy  rgb
    add(210, 305, 1000, 100, 8'hE0, 8'h00, 8'h1C, 8'h00, 0, 1, 0, 10, 5, 0, 0, 0, 12'hF00);
    add(205, 303, 1000, 100, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 1, 0, 5, 3, 0, 0, 0, 12'h000);
    add(410, 510, 1000, 100, 8'hFF, 8'h00, 8'h49, 8'h00, 0, 1, 2, 10, 10, 0, 0, 0, 12'h445);
    add(422, 522, 1000, 100, 8'h6D, 8'h00, 8'h00, 8'h00, 0, 1, 5, 17, 17, 0, 0, 0, 12'h665);
    add(259, 359, 1000, 100, 8'h92, 8'h00, 8'h00, 8'h00, 0, 1, 0, 59, 59, 0, 0, 0, 12'h99A);
    add(260, 300, 1000, 100, 8'hE0, 8'h00, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h00F);
    add(5, 400, 1000, 100, 8'hE0, 8'h00, 8'h1C, 8'h00, 0, 1, 1, 5, 10, 0, 0, 0, 12'hFFF);
    add(5, 400, 1000, 100, 8'hE0, 8'h00, 8'h1C, 8'h03, 1, 1, 1, 5, 10, 0, 0, 0, 12'h00F);
    add(1270, 50, 1000, 100, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'hFFF);
    add(1269, 50, 1000, 100, 8'h00, 8'h00, 8'h1C, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0F0);
    add(700, 790, 1000, 100, 8'h00, 8'h00, 8'h1C, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'hFFF);
    add(700, 789, 1000, 100, 8'h00, 8'h00, 8'h92, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h99A);
    add(1010, 110, 1000, 100, 8'h00, 8'hE0, 8'h1C, 8'h00, 0, 0, 0, 0, 0, 1, 10, 10, 12'hF00);
    add(1010, 110, 1000, 100, 8'h00, 8'hFF, 8'h1C, 8'h00, 0, 0, 0, 0, 0, 1, 10, 10, 12'h0F0);
    add(1032, 132, 1000, 100, 8'h00, 8'h03, 8'h1C, 8'h00, 0, 0, 0, 0, 0, 1, 32, 32, 12'h00F);
    add(1033, 132, 1000, 100, 8'h00, 8'hE0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    add(1005, 105, 1000, 100, 8'h1C, 8'hE0, 8'h03, 8'h00, 0, 1, 7, 5, 5, 1, 5, 5, 12'h0F0);
    add(636, 300, 635, 400, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h996);
    add(634, 300, 635, 400, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h996);
    add(633, 300, 635, 400, 8'h00, 8'h00, 8'hE0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'hF00);
    add(641, 300, 635, 400, 8'h00, 8'h00, 8'h1C, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0F0);
    add(645, 410, 635, 400, 8'h00, 8'hFF, 8'h03, 8'h00, 0, 0, 0, 0, 0, 1, 10, 10, 12'h00F);
    add(600, 300, 635, 400, 8'h00, 8'h00, 8'hE0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 12'hF00);
    for (int i = 1; vq.size() > 0; i++) run_vec(vq.pop_front(), i);

`ifdef COMPOSE_COLLIDE_EN
    check("collide_set", 32'(collide_vec), 32'h080);
    collide_clr = 1'b1;
    step();
    collide_clr = 1'b0;
    check("collide_clr", 32'(collide_vec), 32'h000);
    // collision pixel reaches stage 3 on the same edge as a clear
    hook_x = 11'd1000; hook_y = 10'd100;
    pix_valid = 1'b1; draw_x = 11'd1005; draw_y = 10'd105;
    step();
    pix_valid = 1'b0; spr_data = 8'h1C; hook_data = 8'hE0;
    step();
    collide_clr = 1'b1;
    step();
    collide_clr = 1'b0;
    check("collide_clr_prio", 32'(collide_vec), 32'h000);
    step();
`endif

    // write and hit-test of the same slot in one cycle sees the old entry
    hook_x = 11'd1000; hook_y = 10'd100; bg_data = 8'h00;
    wr_en = 1'b1; wr_idx = 4'd3; wr_x = 11'd50; wr_y = 10'd600; wr_w = 7'd9; wr_h = 7'd9;
    wr_vis = 1'b1; pix_valid = 1'b1; draw_x = 11'd55; draw_y = 10'd605;
    step();
    wr_en = 1'b0;
    check("wr_same_cycle_req", 32'(spr_req), 32'd0);
    step();
    check("wr_next_cycle_req", 32'(spr_req), 32'd1);
    check("wr_next_cycle_idx", 32'(spr_idx), 32'd3);
    check("wr_next_cycle_off", 32'({spr_off_x, spr_off_y}), 32'({7'd5, 7'd5}));
    pix_valid = 1'b0;
    repeat (4) step();

    // three back-to-back pixels, one result per clock
    pipe_bg[0] = 8'h1C; pipe_bg[1] = 8'hE0; pipe_bg[2] = 8'h03;
    pipe_exp[0] = 12'h0F0; pipe_exp[1] = 12'hF00; pipe_exp[2] = 12'h00F;
    for (int c = 0; c < 5; c++) begin
      pix_valid = (c < 3);
      draw_x = 11'(100 + c); draw_y = 10'd100;
      if (c < 3) exp_q.push_back(pipe_exp[c]);
      if (c >= 1 && c <= 3) bg_data = pipe_bg[c-1];
      step();
      if (c >= 2) begin
        check($sformatf("pipe%0d_valid", c - 2), 32'(draw_valid), 32'd1);
        check($sformatf("pipe%0d_rgb", c - 2), 32'({draw_r, draw_g, draw_b}),
              32'(exp_q.pop_front()));
      end
    end
    step();
    check("pipe_drain", 32'(draw_valid), 32'd0);

    // reset mid-frame flushes the pipeline and clears the table
    pix_valid = 1'b1; draw_x = 11'd210; draw_y = 10'd305;
    step();
    check("pre_reset_req", 32'(spr_req), 32'd1);
    pix_valid = 1'b0; bg_data = 8'h1C;
    step();
    rst_n = 1'b0;
    #1;
    check("async_reset_req", 32'(spr_req), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("flushed_valid", 32'(draw_valid), 32'd0);
    step();
    check("flushed_valid2", 32'(draw_valid), 32'd0);
    v.x = 11'd210; v.y = 10'd305; v.hx = 11'd1000; v.hy = 10'd100;
    v.spr = 8'hE0; v.hk = 8'h00; v.bg = 8'h1C; v.en = 8'h00; v.done = 1'b0;
    v.req = 1'b0; v.idx = '0; v.ox = '0; v.oy = '0; v.chk_hk = 1'b0; v.hox = '0; v.hoy = '0;
    v.rgb = 12'h0F0;
    run_vec(v, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
